permutation_iter: RTL

PERMUTATION_ITER -- requirements
Module: permutation_iter

---
 rtl/ascon_pack.sv | 53 +++++
 rtl/ascon_round.sv | 27 ++
 rtl/permutation_iter.sv | 113 +++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// Shared ASCON permutation definitions: state type, round constants,
// S-box table, diffusion rotation amounts and the two layer functions.
package ascon_pack;

    localparam int NB_ROUNDS = 12;

    // x0 sits at index 0, so {x0, x1, x2, x3, x4} builds a state directly.
    typedef logic [0:4][63:0] type_state;

    // Index is the bit-slice {x0, x1, x2, x3, x4}, x0 as MSB.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] round_constant(input logic [3:0] idx);
        return {56'h0, 4'hF - idx, idx};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x,
                                          input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic type_state sbox_layer(input type_state s);
        type_state  r;
        logic [4:0] v;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            v = SBOX[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
            r[0][j] = v[4];
            r[1][j] = v[3];
            r[2][j] = v[2];
            r[3][j] = v[1];
            r[4][j] = v[0];
        end
        return r;
    endfunction

    function automatic type_state diffusion_layer(input type_state s);
        type_state r;
        for (int k = 0; k < 5; k++) begin
            r[k] = s[k] ^ ror64(s[k], ROT_A[k]) ^ ror64(s[k], ROT_B[k]);
        end
        return r;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant add, S-box, diffusion.
// Ports: state_i/state_o state, round_i round index (>11 passes through).
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [4:0] round_i,
    output type_state  state_o
);

    type_state add_s;
    type_state sub_s;
    type_state dif_s;

    always_comb begin
        add_s    = state_i;
        add_s[2] = state_i[2] ^ round_constant(round_i[3:0]);
    end

    assign sub_s = sbox_layer(add_s);
    assign dif_s = diffusion_layer(sub_s);

    // Stages past the last round index are transparent, which lets the
    // final cycle of an unrolled chain apply fewer rounds.
    assign state_o = (round_i > 5'd11) ? state_i : dif_s;

endmodule

// File: rtl/permutation_iter.sv
// Iterative ASCON permutation, UNROLL rounds per clock, n = 0..12 rounds.
// Ports: clock_i, resetb_i, start_i/rounds_i/state_i request,
//        ready_o, done_o pulse, state_o result, round_o next round index.
module permutation_iter
    import ascon_pack::*;
#(
    parameter int NB_ROUNDS_MAX = 12,
    parameter int UNROLL        = 1
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [3:0] rounds_i,
    input  type_state  state_i,
    output logic       ready_o,
    output logic       done_o,
    output type_state  state_o,
    output logic [3:0] round_o
);

    localparam logic [3:0] NB_MAX = 4'(NB_ROUNDS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } fsm_t;

    fsm_t       fsm_q;
    type_state  state_q;
    logic [3:0] round_q;
    logic       ready_q;
    logic       done_q;

    logic [3:0] n_clamp;
    logic [3:0] round_start;
    logic [4:0] round_sum;
    logic       last_step;

    type_state  chain [UNROLL+1];

    assign n_clamp     = (rounds_i > NB_MAX) ? NB_MAX : rounds_i;
    // n rounds use the tail of the schedule: indices 12-n .. 11.
    assign round_start = 4'd12 - n_clamp;
    assign round_sum   = {1'b0, round_q} + 5'(UNROLL);
    assign last_step   = (round_sum >= 5'd12);

    assign chain[0] = state_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        ascon_round u_round (
            .state_i (chain[k]),
            .round_i ({1'b0, round_q} + 5'(k)),
            .state_o (chain[k+1])
        );
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (fsm_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= state_i;
                        round_q <= round_start;
                        ready_q <= 1'b0;
                        fsm_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // n = 0 starts at index 12: nothing to apply.
                    if (round_q >= 4'd12) begin
                        done_q <= 1'b1;
                        fsm_q  <= ST_DONE;
                    end else begin
                        fsm_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= chain[UNROLL];
                    if (last_step) begin
                        round_q <= 4'd12;
                        done_q  <= 1'b1;
                        fsm_q   <= ST_DONE;
                    end else begin
                        round_q <= round_sum[3:0];
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    fsm_q   <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    fsm_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign state_o = state_q;
    assign round_o = round_q;

endmodule
